// File: rtl/bit_order_serializer.sv
// bit_order_serializer
//   Parallel-to-serial transmitter. Accepts a DATA_WIDTH-bit word on a
//   valid/ready handshake and emits it one bit per accepted beat, MSB-first
//   or LSB-first as selected per word. LSB-first words are bit-reversed at
//   load time so the serial path always shifts out of the top bit.
//
// Ports
//   clk         clock, rising-edge
//   reset       asynchronous, active-high reset
//   din         parallel word to transmit
//   din_valid   din / lsb_first valid this cycle
//   din_ready   block can accept a word this cycle
//   lsb_first   1 = bit 0 first, 0 = bit DATA_WIDTH-1 first (sampled at accept)
//   dout        current serial bit
//   dout_valid  dout is a valid beat
//   dout_last   current beat is the final bit of the word
//   dout_ready  sink accepts the current beat this cycle
module bit_order_serializer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  lsb_first,
  output logic                  dout,
  output logic                  dout_valid,
  output logic                  dout_last,
  input  logic                  dout_ready
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] sreg;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] din_rev;
  logic                  word_acc;
  logic                  beat_acc;

  always_comb begin
    din_rev = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      din_rev[i] = din[DATA_WIDTH-1-i];
    end
  end

  // Outputs depend only on registered state so nothing from din leaks through.
  assign dout       = (state == SHIFT) && sreg[DATA_WIDTH-1];
  assign dout_valid = (state == SHIFT);
  assign dout_last  = (state == SHIFT) && (cnt == CW'(DATA_WIDTH-1));

  // Combinational from dout_ready so a new word can load on the last-beat
  // edge, giving gapless back-to-back words.
  assign din_ready = !reset && ((state == IDLE) || (dout_last && dout_ready));

  assign word_acc = din_valid && din_ready;
  assign beat_acc = dout_valid && dout_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (word_acc) begin
      // In SHIFT this only happens on the last-beat accept, so loading here
      // also retires the finishing word.
      sreg  <= lsb_first ? din_rev : din;
      cnt   <= '0;
      state <= SHIFT;
    end else if (beat_acc) begin
      cnt <= cnt + CW'(1);
      if (dout_last) begin
        state <= IDLE;
        sreg  <= '0;
      end else begin
        sreg <= {sreg[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_bit_order_serializer.sv
// tb_bit_order_serializer
//   Self-checking bench for bit_order_serializer (DATA_WIDTH = 32). A queue
//   of expected serial bits models the block: each accepted word appends its
//   bits in transmit order, each accepted beat pops one. Every cycle the
//   DUT outputs are compared to the head of that queue, and completed words
//   reassembled from dout are compared to known values.
module tb_bit_order_serializer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         lsb_first;
  logic         dout;
  logic         dout_valid;
  logic         dout_last;
  logic         dout_ready;

  bit_order_serializer #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .lsb_first  (lsb_first),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit           q[$];        // expected serial bits still to be sent
  logic [W-1:0] pend_d[$];   // words waiting to be offered
  bit           pend_l[$];
  logic [W-1:0] done[$];     // words reassembled from dout
  logic [W-1:0] exp_words[$];
  logic [W-1:0] col;
  bit           word_taken;

  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("FAIL %s", tag);
  endtask

  // Entered at posedge+1 with inputs already driven; checks mid-cycle, then
  // advances the model across the next rising edge.
  task automatic cycle();
    bit ev, el, ed, er, beat;
    logic d_obs;
    #2;
    ev = (q.size() > 0);
    ed = ev ? q[0] : 1'b0;
    el = (q.size() == 1);
    er = !reset && (!ev || (el && dout_ready));
    chk("dout_valid", 32'(dout_valid), 32'(ev));
    chk("dout", 32'(dout), 32'(ed));
    chk("dout_last", 32'(dout_last), 32'(el));
    chk("din_ready", 32'(din_ready), 32'(er));
    d_obs      = dout;
    beat       = ev && dout_ready;
    word_taken = din_valid && er;
    @(posedge clk);
    if (reset) begin
      q.delete();
      col = '0;
      word_taken = 1'b0;
    end else begin
      if (beat) begin
        col = {col[W-2:0], d_obs};
        void'(q.pop_front());
        if (el) done.push_back(col);
      end
      if (word_taken) begin
        for (int k = 0; k < W; k++) q.push_back(lsb_first ? din[k] : din[W-1-k]);
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      din       = $urandom;
      lsb_first = 1'($urandom_range(0, 1));
      cycle();
    end
  endtask

  task automatic push_word(input logic [W-1:0] d, input bit l);
    pend_d.push_back(d);
    pend_l.push_back(l);
    exp_words.push_back(l ? rev(d) : d);
  endtask

  // Offers pending words and drains the bit queue. stall_beat selects a beat
  // index (0-based) that is held off for stall_len cycles; rnd randomizes
  // dout_ready; beat_limit stops after that many beat accepts.
  task automatic run(input int max_cycles, input int stall_beat, input int stall_len,
                     input bit rnd, input int beat_limit);
    int n     = 0;
    int beats = 0;
    int sl    = stall_len;
    while ((pend_d.size() > 0 || q.size() > 0) && (beat_limit < 0 || beats < beat_limit)) begin
      if (n >= max_cycles) begin
        fail_now("timeout");
        break;
      end
      din_valid = (pend_d.size() > 0);
      din       = din_valid ? pend_d[0] : W'($urandom);
      lsb_first = din_valid ? pend_l[0] : 1'($urandom_range(0, 1));
      if (rnd) dout_ready = ($urandom_range(0, 3) != 0);
      else if (q.size() > 0 && (W - q.size()) == stall_beat && sl > 0) begin
        dout_ready = 1'b0;
        sl--;
      end else dout_ready = 1'b1;
      if (dout_ready && q.size() > 0) beats++;
      cycle();
      n++;
      if (word_taken) begin
        void'(pend_d.pop_front());
        void'(pend_l.pop_front());
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [W-1:0] v);
    if (done.size() == 0) fail_now({tag, " missing"});
    else chk(tag, done.pop_front(), v);
  endtask

  task automatic check_done_against_model();
    while (exp_words.size() > 0) begin
      if (done.size() == 0) begin
        fail_now("word missing");
        exp_words.delete();
      end else chk("random word", done.pop_front(), exp_words.pop_front());
    end
  endtask

  initial begin
    reset      = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    lsb_first  = 1'b0;
    dout_ready = 1'b1;
    col        = '0;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    reset = 1'b0;

    // idle: nothing valid, always ready
    idle(10);

    // MSB-first, no back-pressure
    push_word(32'hA5A5A5A5, 1'b0);
    run(200, -1, 0, 1'b0, -1);
    idle(1);
    expect_word("msb A5A5A5A5", 32'hA5A5A5A5);

    // LSB-first and the same word MSB-first
    push_word(32'h12345678, 1'b1);
    run(200, -1, 0, 1'b0, -1);
    idle(1);
    expect_word("lsb 12345678", 32'h1E6A2C48);
    push_word(32'h12345678, 1'b0);
    run(200, -1, 0, 1'b0, -1);
    idle(1);
    expect_word("msb 12345678", 32'h12345678);

    // back-to-back, din_valid held across the word boundary
    push_word(32'h80000001, 1'b1);
    push_word(32'hFFFFFFFF, 1'b0);
    run(300, -1, 0, 1'b0, -1);
    idle(1);
    expect_word("b2b first", 32'h80000001);
    expect_word("b2b second", 32'hFFFFFFFF);

    // back-pressure at beat 5 for 3 cycles
    push_word(32'hA5A5A5A5, 1'b0);
    run(200, 4, 3, 1'b0, -1);
    idle(1);
    expect_word("stall A5A5A5A5", 32'hA5A5A5A5);
    exp_words.delete();

    // asynchronous reset after beat 10
    push_word(32'h12345678, 1'b1);
    run(200, -1, 0, 1'b0, 10);
    #2;
    reset = 1'b1;
    #1;
    chk("async dout", 32'(dout), 32'd0);
    chk("async dout_valid", 32'(dout_valid), 32'd0);
    chk("async dout_last", 32'(dout_last), 32'd0);
    chk("async din_ready", 32'(din_ready), 32'd0);
    q.delete();
    pend_d.delete();
    pend_l.delete();
    exp_words.delete();
    col = '0;
    @(posedge clk);
    #1;
    cycle();
    reset = 1'b0;
    push_word(32'h00000000, 1'b0);
    run(200, -1, 0, 1'b0, -1);
    idle(1);
    expect_word("post-reset zero", 32'h00000000);
    if (done.size() != 0) fail_now("extra word after reset");
    exp_words.delete();

    // randomized words with random back-pressure
    for (int i = 0; i < 20; i++) push_word(W'($urandom), 1'($urandom_range(0, 1)));
    run(5000, -1, 0, 1'b1, -1);
    idle(2);
    check_done_against_model();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
